// File: rtl/computational_unit_mc.sv
// Nibble-CPU datapath generalised to DW-bit data: architectural register set,
// data_bus source mux, single-cycle ALU with carry/borrow flag, and an
// iterative shift-add multiplier that holds off further r writes while busy.
module computational_unit_mc #(
  parameter int unsigned DW       = 4,
  parameter int unsigned MUL_ITER = DW
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] imm,
  input  logic          i_sel,
  input  logic          x_sel,
  input  logic          y_sel,
  input  logic [3:0]    source_sel,
  input  logic [8:0]    reg_en,
  input  logic [DW-1:0] dm,
  input  logic [DW-1:0] i_pins,
  output logic [DW-1:0] data_bus,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] m,
  output logic [DW-1:0] i,
  output logic [DW-1:0] o_reg,
  output logic [DW-1:0] r,
  output logic          r_eq_0,
  output logic          carry,
  output logic          mul_busy,
  output logic          mul_done
);

  localparam int unsigned CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_ITER - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mul_state_e;

  // architectural registers
  logic [DW-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [DW-1:0] m_q, m_d, i_q, i_d, o_reg_q, o_reg_d, r_q, r_d;
  logic          r_eq_0_q, r_eq_0_d, carry_q, carry_d;
  logic          mul_done_q, mul_done_d;

  // multiplier state
  mul_state_e      state_q, state_d;
  logic [2*DW-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hi_q, hi_d;

  // ALU decode results
  logic [DW-1:0] x_op, y_op, alu_res, mul_res;
  logic [2:0]    op;
  logic          op_q;
  logic          alu_wr, alu_cwr, alu_c;
  logic          mul_start, mul_hi, mul_load;

  // reg_en[7] has no register behind it
  logic unused_reg_en7;
  assign unused_reg_en7 = reg_en[7];

  assign op       = alu_op[2:0];
  assign op_q     = alu_op[3];
  assign x_op     = x_sel ? x1_q : x0_q;
  assign y_op     = y_sel ? y1_q : y0_q;
  assign mul_busy = (state_q == S_RUN);

  // data_bus source mux; unused codes read as zero
  always_comb begin
    data_bus = '0;
    case (source_sel)
      4'd0:    data_bus = x0_q;
      4'd1:    data_bus = x1_q;
      4'd2:    data_bus = y0_q;
      4'd3:    data_bus = y1_q;
      4'd4:    data_bus = r_q;
      4'd5:    data_bus = m_q;
      4'd6:    data_bus = i_q;
      4'd7:    data_bus = dm;
      4'd8:    data_bus = imm;
      4'd9:    data_bus = i_pins;
      default: data_bus = '0;
    endcase
  end

  // ALU decode: single-cycle results and multiply start requests, gated off while busy
  always_comb begin
    alu_wr    = 1'b0;
    alu_cwr   = 1'b0;
    alu_c     = 1'b0;
    alu_res   = '0;
    mul_start = 1'b0;
    mul_hi    = 1'b0;
    if (reg_en[4] && !mul_busy) begin
      case (op)
        3'b000: begin
          if (!op_q) begin
            alu_wr  = 1'b1;
            alu_res = '0 - x_op;
          end
        end
        3'b001: begin
          alu_wr  = 1'b1;
          alu_cwr = 1'b1;
          alu_res = x_op - y_op;
          alu_c   = (x_op < y_op);
        end
        3'b010: begin
          alu_wr  = 1'b1;
          alu_cwr = 1'b1;
          {alu_c, alu_res} = {1'b0, x_op} + {1'b0, y_op};
        end
        3'b011: begin
          mul_start = 1'b1;
          mul_hi    = 1'b1;
        end
        3'b100: mul_start = 1'b1;
        3'b101: begin
          alu_wr  = 1'b1;
          alu_res = x_op ^ y_op;
        end
        3'b110: begin
          alu_wr  = 1'b1;
          alu_res = x_op & y_op;
        end
        3'b111: begin
          if (!op_q) begin
            alu_wr  = 1'b1;
            alu_res = ~x_op;
          end
        end
        default: ;
      endcase
    end
  end

  // multiplier next state: one shift-add step per clock, final step feeds r directly
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    mul_load = 1'b0;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res  = hi_q ? acc_step[2*DW-1:DW] : acc_step[DW-1:0];
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          state_d  = S_RUN;
          acc_d    = '0;
          mcand_d  = {{DW{1'b0}}, x_op};
          mplier_d = y_op;
          cnt_d    = '0;
          hi_d     = mul_hi;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          mul_load = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // architectural register next state
  always_comb begin
    x0_d       = reg_en[0] ? data_bus : x0_q;
    x1_d       = reg_en[1] ? data_bus : x1_q;
    y0_d       = reg_en[2] ? data_bus : y0_q;
    y1_d       = reg_en[3] ? data_bus : y1_q;
    m_d        = reg_en[5] ? data_bus : m_q;
    o_reg_d    = reg_en[8] ? data_bus : o_reg_q;
    i_d        = i_q;
    if (reg_en[6]) begin
      i_d = i_sel ? (i_q + m_q) : data_bus;
    end
    r_d        = r_q;
    r_eq_0_d   = r_eq_0_q;
    if (alu_wr) begin
      r_d      = alu_res;
      r_eq_0_d = (alu_res == '0);
    end else if (mul_load) begin
      r_d      = mul_res;
      r_eq_0_d = (mul_res == '0);
    end
    carry_d    = alu_cwr ? alu_c : carry_q;
    mul_done_d = mul_load;
  end

  // register set, flags and done pulse
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      m_q        <= '0;
      i_q        <= '0;
      o_reg_q    <= '0;
      r_q        <= '0;
      r_eq_0_q   <= 1'b1;
      carry_q    <= 1'b0;
      mul_done_q <= 1'b0;
    end else begin
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      m_q        <= m_d;
      i_q        <= i_d;
      o_reg_q    <= o_reg_d;
      r_q        <= r_d;
      r_eq_0_q   <= r_eq_0_d;
      carry_q    <= carry_d;
      mul_done_q <= mul_done_d;
    end
  end

  // multiplier state; reset aborts and discards any product in flight
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
    end
  end

  assign x0       = x0_q;
  assign x1       = x1_q;
  assign y0       = y0_q;
  assign y1       = y1_q;
  assign m        = m_q;
  assign i        = i_q;
  assign o_reg    = o_reg_q;
  assign r        = r_q;
  assign r_eq_0   = r_eq_0_q;
  assign carry    = carry_q;
  assign mul_done = mul_done_q;

endmodule
